// File: rtl/avalon_mm_burst_ram_slave.sv
// Avalon-MM burst-capable RAM slave: single/burst reads and writes with byteenables,
// fixed two-cycle read latency and wrap-around burst addressing.
module avalon_mm_burst_ram_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WORDS = 256,
  parameter int MAX_BURST   = 8,
  parameter int BC_WIDTH    = $clog2(MAX_BURST) + 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic [BC_WIDTH-1:0]     avs_burstcount,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
  input  logic [DATA_WIDTH-1:0]   avs_writedata,
  output logic [DATA_WIDTH-1:0]   avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    avs_waitrequest,
  output logic                    burst_active
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int WA_W  = $clog2(DEPTH_WORDS);
  localparam logic [WA_W-1:0]     WA_ONE = WA_W'(1);
  localparam logic [BC_WIDTH-1:0] BC_ONE = BC_WIDTH'(1);
  localparam logic [BC_WIDTH-1:0] BC_MAX = BC_WIDTH'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  // Handshake: a command (read or write) is taken on a rising edge where it is
  // asserted and avs_waitrequest is low; write beats inside a burst likewise.
  state_t                state_q, state_d;
  logic [WA_W-1:0]       waddr_q, waddr_d;
  logic [BC_WIDTH-1:0]   wleft_q, wleft_d;
  logic [WA_W-1:0]       raddr_q, raddr_d;
  logic [BC_WIDTH-1:0]   rleft_q, rleft_d;
  logic                  in_reset_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [WA_W-1:0]       cmd_word;
  logic [BC_WIDTH-1:0]   cmd_len;
  logic                  cmd_accept;
  logic                  mem_we;
  logic                  mem_we_g;
  logic [WA_W-1:0]       mem_waddr;
  logic                  rd_en;
  logic                  unused_addr;

  assign cmd_word    = avs_address[OFF_W +: WA_W];
  assign unused_addr = ^avs_address;

  always_comb begin
    if (avs_burstcount == '0) begin
      cmd_len = BC_ONE;
    end else if (avs_burstcount > BC_MAX) begin
      cmd_len = BC_MAX;
    end else begin
      cmd_len = avs_burstcount;
    end
  end

  assign avs_waitrequest   = in_reset_q | (state_q == ST_READ);
  assign cmd_accept        = (avs_read | avs_write) & ~avs_waitrequest;
  assign burst_active      = (state_q != ST_IDLE);
  assign avs_readdatavalid = rvalid_q;
  assign avs_readdata      = rdata_q;

  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    wleft_d   = wleft_q;
    raddr_d   = raddr_q;
    rleft_d   = rleft_q;
    mem_we    = 1'b0;
    mem_waddr = waddr_q;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) begin
          // Write has priority; a simultaneous read is dropped.
          if (avs_write) begin
            mem_we    = 1'b1;
            mem_waddr = cmd_word;
            if (cmd_len != BC_ONE) begin
              state_d = ST_WRITE;
              waddr_d = cmd_word + WA_ONE;
              wleft_d = cmd_len - BC_ONE;
            end
          end else begin
            state_d = ST_READ;
            raddr_d = cmd_word;
            rleft_d = cmd_len;
          end
        end
      end
      ST_WRITE: begin
        if (avs_write) begin
          mem_we  = 1'b1;
          waddr_d = waddr_q + WA_ONE;
          wleft_d = wleft_q - BC_ONE;
          if (wleft_q == BC_ONE) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        // One extra cycle after the last fetch lets the final registered beat drain.
        if (rleft_q != '0) begin
          rd_en   = 1'b1;
          raddr_d = raddr_q + WA_ONE;
          rleft_d = rleft_q - BC_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_we_g = mem_we & reset_reset_n;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ST_IDLE;
      waddr_q    <= '0;
      wleft_q    <= '0;
      raddr_q    <= '0;
      rleft_q    <= '0;
      in_reset_q <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      wleft_q    <= wleft_d;
      raddr_q    <= raddr_d;
      rleft_q    <= rleft_d;
      in_reset_q <= 1'b0;
      rvalid_q   <= rd_en;
      if (rd_en) begin
        rdata_q <= mem_q[raddr_q];
      end
    end
  end

  // Storage is never cleared by reset.
  always_ff @(posedge clk_clk) begin
    if (mem_we_g) begin
      for (int b = 0; b < BYTES; b++) begin
        if (avs_byteenable[b]) begin
          mem_q[mem_waddr][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_burst_ram_slave.sv
// Bench for avalon_mm_burst_ram_slave: directed and random Avalon-MM traffic against a word-array model.
module tb_avalon_mm_burst_ram_slave;

  localparam int AW    = 32;
  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int MAXB  = 8;
  localparam int BCW   = 4;

  logic            clk_clk = 1'b0;
  logic            reset_reset_n;
  logic [AW-1:0]   avs_address;
  logic [BCW-1:0]  avs_burstcount;
  logic            avs_read;
  logic            avs_write;
  logic [DW/8-1:0] avs_byteenable;
  logic [DW-1:0]   avs_writedata;
  logic [DW-1:0]   avs_readdata;
  logic            avs_readdatavalid;
  logic            avs_waitrequest;
  logic            burst_active;

  avalon_mm_burst_ram_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB), .BC_WIDTH(BCW)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .avs_address(avs_address),
    .avs_burstcount(avs_burstcount),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_byteenable(avs_byteenable),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest),
    .burst_active(burst_active)
  );

  // Clock / cycle counter
  always #5 clk_clk = ~clk_clk;
  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model and scoreboard
  logic [DW-1:0]   model_mem [DEPTH];
  logic [DW-1:0]   wdata_buf [MAXB];
  logic [DW/8-1:0] be_buf [MAXB];
  logic [DW-1:0]   exp_q[$];
  int              exp_cyc_q[$];
  bit              mon_en = 1'b0;
  logic [DW-1:0]   hold_ref = '0;
  logic [DW-1:0]   mon_e;
  int              mon_ec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_len(input logic [BCW-1:0] bc);
    if (bc == 0) return 1;
    if (int'(bc) > MAXB) return MAXB;
    return int'(bc);
  endfunction

  function automatic int word_of(input logic [AW-1:0] addr);
    return int'((addr >> 1) % DEPTH);
  endfunction

  // Monitor: every readdatavalid beat must match the head of the expected queue in data and cycle.
  always @(negedge clk_clk) begin
    if (mon_en) begin
      if (avs_readdatavalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdv_unexpected: readdatavalid=1 data 0x%0h at cycle %0d, expected no beat", avs_readdata, cyc);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_ec = exp_cyc_q.pop_front();
          check("rd_data", avs_readdata, mon_e);
          check("rd_cycle", cyc, mon_ec);
          hold_ref = mon_e;
        end
      end else begin
        if (reset_reset_n === 1'b0) hold_ref = '0;
        check("rd_hold", avs_readdata, hold_ref);
      end
    end
  end

  // Driver tasks: each starts and ends 1 time unit after a rising edge.
  task automatic wait_ready(input string name);
    int guard = 0;
    while (avs_waitrequest !== 1'b0 && guard < 64) begin
      @(posedge clk_clk); #1;
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: waitrequest=%b after %0d cycles, expected 0", name, avs_waitrequest, guard);
    end
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc,
                             input int idle_after, input int idle_n, input bit with_read);
    int n;
    int word;
    n = eff_len(bc);
    word = word_of(addr);
    for (int k = 0; k < n; k++) begin
      avs_write      = 1'b1;
      avs_writedata  = wdata_buf[k];
      avs_byteenable = be_buf[k];
      if (k == 0) begin
        avs_address    = addr;
        avs_burstcount = bc;
        avs_read       = with_read;
      end else begin
        avs_address    = $urandom;
        avs_burstcount = BCW'($urandom);
        avs_read       = 1'($urandom);
        check("wr_burst_active", burst_active, 1);
      end
      wait_ready("wr");
      @(posedge clk_clk); #1;
      for (int b = 0; b < DW/8; b++)
        if (be_buf[k][b]) model_mem[(word + k) % DEPTH][b*8 +: 8] = wdata_buf[k][b*8 +: 8];
      avs_write = 1'b0;
      avs_read  = 1'b0;
      if (k == idle_after) repeat (idle_n) begin @(posedge clk_clk); #1; end
    end
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [BCW-1:0] bc, input bit chk_wr);
    int n;
    int word;
    int t;
    n = eff_len(bc);
    word = word_of(addr);
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    avs_address    = addr;
    avs_burstcount = bc;
    avs_byteenable = 2'($urandom);
    wait_ready("rd");
    t = cyc;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[(word + k) % DEPTH]);
      exp_cyc_q.push_back(t + 2 + k);
    end
    @(posedge clk_clk); #1;
    avs_read       = 1'b0;
    avs_address    = $urandom;
    avs_burstcount = BCW'($urandom);
    if (chk_wr) begin
      check("rd_burst_active", burst_active, 1);
      for (int k = 0; k <= n; k++) begin
        check("rd_waitrequest_high", avs_waitrequest, 1);
        @(posedge clk_clk); #1;
      end
      check("rd_waitrequest_low", avs_waitrequest, 0);
      check("rd_idle_after", burst_active, 0);
    end
  endtask

  task automatic fill_bufs(input bit rand_be);
    for (int k = 0; k < MAXB; k++) begin
      wdata_buf[k] = DW'($urandom);
      be_buf[k]    = rand_be ? 2'($urandom) : 2'b11;
    end
  endtask

  initial begin
    int guard;
    reset_reset_n  = 1'b0;
    avs_address    = '0;
    avs_burstcount = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_byteenable = '0;
    avs_writedata  = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("reset_waitrequest", avs_waitrequest, 1);
    check("reset_rdv", avs_readdatavalid, 0);
    check("reset_readdata", avs_readdata, 0);
    check("reset_burst_active", burst_active, 0);
    reset_reset_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_clk); #1;
    check("release_waitrequest", avs_waitrequest, 0);

    // Give every word a known value.
    for (int blk = 0; blk < DEPTH / MAXB; blk++) begin
      fill_bufs(1'b0);
      write_burst(AW'(blk * MAXB * 2), 4'd8, -1, 0, 1'b0);
    end

    // Single writes then single reads
    be_buf[0] = 2'b11;
    wdata_buf[0] = 16'h0101;
    write_burst(32'h0, 4'd1, -1, 0, 1'b0);
    wdata_buf[0] = 16'h0202;
    write_burst(32'h2, 4'd1, -1, 0, 1'b0);
    read_burst(32'h0, 4'd1, 1'b1);
    read_burst(32'h2, 4'd1, 1'b1);

    // Burst of 0..7
    for (int k = 0; k < MAXB; k++) begin
      wdata_buf[k] = DW'(k);
      be_buf[k]    = 2'b11;
    end
    write_burst(32'h0, 4'd8, -1, 0, 1'b0);
    read_burst(32'h0, 4'd8, 1'b1);

    // Byte masking
    wdata_buf[0] = 16'hFFFF;
    be_buf[0]    = 2'b11;
    write_burst(32'h4, 4'd1, -1, 0, 1'b0);
    wdata_buf[0] = 16'h1234;
    be_buf[0]    = 2'b01;
    write_burst(32'h4, 4'd1, -1, 0, 1'b0);
    check("byteenable_model", model_mem[2], 16'hFF34);
    read_burst(32'h4, 4'd1, 1'b1);

    // Wrap past top of memory with idle cycles between beats 1 and 2
    fill_bufs(1'b0);
    write_burst(32'h1FC, 4'd4, 1, 2, 1'b0);
    read_burst(32'h1FC, 4'd4, 1'b1);

    // Burstcount 0 and clamping
    fill_bufs(1'b0);
    write_burst(32'h10, 4'd0, -1, 0, 1'b0);
    check("bc0_write_idle", burst_active, 0);
    read_burst(32'h10, 4'd0, 1'b1);
    fill_bufs(1'b0);
    write_burst(32'h40, 4'd15, -1, 0, 1'b0);
    check("bc_clamp_write_idle", burst_active, 0);
    read_burst(32'h40, 4'd12, 1'b1);

    // Read and write together: write wins, no read data
    fill_bufs(1'b0);
    write_burst(32'h30, 4'd1, -1, 0, 1'b1);
    repeat (4) begin @(posedge clk_clk); #1; end
    check("rw_both_no_read", exp_q.size(), 0);
    read_burst(32'h30, 4'd1, 1'b1);

    // Reset during beat 3 of an 8-beat read
    read_burst(32'h0, 4'd8, 1'b0);
    repeat (4) begin @(posedge clk_clk); #1; end
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;
    check("rst_rdv_drop", avs_readdatavalid, 0);
    check("rst_beats_seen", exp_q.size(), 4);
    exp_q.delete();
    exp_cyc_q.delete();
    check("rst_held_waitrequest", avs_waitrequest, 1);
    check("rst_held_burst_active", burst_active, 0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;
    check("rst_release_waitrequest", avs_waitrequest, 0);
    read_burst(32'h0, 4'd1, 1'b1);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0]  addr;
      logic [BCW-1:0] bc;
      addr = $urandom;
      bc   = BCW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_bufs(1'b1);
        write_burst(addr, bc, $urandom_range(0, 7), $urandom_range(0, 2), 1'b0);
      end else begin
        read_burst(addr, bc, 1'($urandom_range(0, 1)));
      end
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk_clk); #1;
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_mm_burst_ram_slave.md
Name: avalon_mm_burst_ram_slave

Overview:
- Avalon-MM slave memory inside my_sys, directly downstream of the Avalon-MM master BFM.
- Accepts single and burst reads and writes with byteenables, stalls via waitrequest, and returns read data on readdatavalid.
- Fixed read latency.
- This is the endpoint the system-level sequential and burst tests target.

Parameters:
- ADDR_WIDTH, 32, byte address width of avs_address.
- DATA_WIDTH, 16, data width; multiple of 8.
- DEPTH_WORDS, 256, memory depth in words; power of 2.
- MAX_BURST, 8, largest legal burstcount.
- BC_WIDTH, $clog2(MAX_BURST)+1, width of avs_burstcount.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset_n  in  1  reset; synchronous, active-low.
- avs_address  in  ADDR_WIDTH  byte address; sampled on the first beat only.
- avs_burstcount  in  BC_WIDTH  beats in the burst; sampled on the first beat only.
- avs_read  in  1  read request.
- avs_write  in  1  write request / write beat valid.
- avs_byteenable  in  DATA_WIDTH/8  per-byte write enable.
- avs_writedata  in  DATA_WIDTH  write data.
- avs_readdata  out  DATA_WIDTH  read data.
- avs_readdatavalid  out  1  readdata qualifier.
- avs_waitrequest  out  1  slave stall.
- burst_active  out  1  high while a burst is in progress (state != IDLE).

Behaviour:
- Reset (reset_reset_n=0 at a clock edge):
  - state=IDLE; avs_waitrequest=1 while reset is held, 0 on the first cycle after release.
  - avs_readdatavalid=0, avs_readdata=0, burst_active=0.
  - Memory contents are not cleared.
- Address mapping:
  - word = (avs_address >> log2(DATA_WIDTH/8)) mod DEPTH_WORDS; low byte-offset bits are ignored.
  - Burst beat k targets (word+k) mod DEPTH_WORDS, so bursts wrap past the top of memory to word 0.
- Burstcount rules: 0 is treated as 1; values > MAX_BURST are clamped to MAX_BURST.
- Command acceptance: a command is accepted on a cycle with (avs_read|avs_write)=1 and avs_waitrequest=0.
- States: IDLE, WRITE, READ.
- IDLE:
  - waitrequest=0.
  - Accepted write with burstcount N: beat 0 is written that cycle. N=1 stays in IDLE; N>1 goes to WRITE with remaining=N-1 and the next address latched.
  - Accepted read: latch word and N, go to READ.
  - read and write both high: write wins; the read is dropped.
- WRITE:
  - waitrequest=0; each cycle with avs_write=1 writes one beat and increments the address.
  - avs_write=0 is a master idle cycle; the burst is held.
  - avs_read is ignored; address and burstcount are ignored.
  - Returns to IDLE on the cycle the last beat is written.
- READ:
  - waitrequest=1 from the cycle after acceptance (T+1) through the cycle of the last data beat.
  - Memory is read one word per cycle starting at T+1.
  - readdata is registered, so beat k appears with readdatavalid=1 at cycle T+2+k, with no gaps.
  - Returns to IDLE after the last beat; waitrequest=0 at T+2+N.
- Write byte masking: only bytes with byteenable=1 are updated; a beat with byteenable=0 writes nothing but still consumes a beat.
- Ordering: a read accepted in the cycle after a write completes returns the new data; the serialized FSM gives no read/write overlap.
- Reset mid-operation:
  - Mid-write: beats already written persist.
  - Mid-read: the read aborts and readdatavalid drops to 0 the next cycle.
- readdata holds its last value when readdatavalid=0.

Test Plan:
- Single writes: write 0x0101 @0x0, 0x0202 @0x2, byteenable 2'b11; single reads -> readdata 0x0101 then 0x0202, each with readdatavalid 2 cycles after acceptance.
- Burst: write burst N=8 @0x0 of data 0..7, then read burst N=8 @0x0 -> 8 contiguous readdatavalid beats returning 0x0000..0x0007; waitrequest=1 throughout, low the cycle after beat 7.
- Byteenable: write 0xFFFF @0x4, then write 0x1234 with byteenable 2'b01 -> read returns 0xFF34.
- Wrap and idle beats: write burst N=4 @byte 0x1FC (word 254) with write deasserted 2 cycles between beats 1 and 2 -> words 254, 255, 0, 1 updated; read burst confirms the values.
- Reset mid-read: reset_reset_n=0 during beat 3 of an N=8 read -> readdatavalid=0 next cycle; after release waitrequest=0 and a fresh single read @0x0 returns correct data.
- Burstcount edge cases: burstcount=0 -> one beat transferred; read and write high together in IDLE -> only the write performed, no readdatavalid.
